// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
//   parity_t   : parity mode selected at elaboration time
//   state_t    : bit-level receiver FSM states
//   frame_bits : total line bits per frame (start + data + parity + stop)
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  function automatic int frame_bits(input int data_bits, input parity_t parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   push/wdata : write request; accepted when not full, or when full with a
//                same-cycle pop
//   pop        : read request; ignored when empty
//   rdata      : head entry, valid whenever empty = 0
//   full/empty : occupancy flags; count : entries held (0..DEPTH)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with a buffered valid/ready output.
//   rx                      : async serial input, idles high
//   data_received/parity_err/frame_err : head entry of the frame FIFO
//   valid/ready             : FIFO not empty / consumer accepts head entry
//   overrun                 : 1-cycle pulse when a finished frame is dropped
// Frames are sampled mid-bit off a 2-flop synchronised copy of rx; every
// completed frame, errored or not, is pushed at the last stop-bit sample.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 5208,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PARITY_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_M1 = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_M1 = BW'(STOP_BITS - 1);

  logic                 rx_meta, rx_s, rx_prev;
  logic [2:0]           sync_vld;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 push, pop, full, empty;
  logic [EW-1:0]        head;
  logic [AW:0]          count;

  // sync_vld marks how many stages of the rx pipe hold real line samples
  // since reset. Edge detection waits for rx_prev to be real, so a line that
  // was already low across reset release never looks like a fresh start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= '0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sr      <= sr_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sr_n    = sr;
    perr_n  = perr;
    ferr_n  = ferr;
    push    = 1'b0;
    case (state)
      IDLE: if (sync_vld[2] && rx_prev && !rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n   = '0;
        bit_n   = '0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        state_n = rx_s ? IDLE : DATA;  // high at mid start bit: glitch
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == BIT_M1) begin
        cnt_n = '0;
        sr_n  = {rx_s, sr[DATA_BITS-1:1]};
        if (bit_cnt == DATA_M1) begin
          bit_n   = '0;
          state_n = (PARITY == PARITY_NONE) ? STOP : PAR;
        end else bit_n = bit_cnt + 1'b1;
      end else cnt_n = cnt + 1'b1;
      PAR: if (cnt == BIT_M1) begin
        cnt_n   = '0;
        perr_n  = ((^sr) ^ rx_s) != (PARITY == PARITY_ODD);
        state_n = STOP;
      end else cnt_n = cnt + 1'b1;
      STOP: if (cnt == BIT_M1) begin
        cnt_n  = '0;
        ferr_n = ferr | !rx_s;
        if (bit_cnt == STOP_M1) begin
          // Leave at mid stop bit so the next start edge is not missed.
          push    = 1'b1;
          bit_n   = '0;
          state_n = IDLE;
        end else bit_n = bit_cnt + 1'b1;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end

  assign pop = ready && !empty;

  uart_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({sr_n, perr_n, ferr_n}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {data_received, parity_err, frame_err} = head;
  assign valid = |count;

  // Dropped only when the head does not leave in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push && full && !pop;
  end

endmodule
